// File: rtl/axi4_burst_pkg.sv
// Shared types and helpers for the AXI4 burst slave memory.
//   burst_e   : AXI burst encoding
//   RESP_*    : AXI response codes used by this slave
//   wstate_e  : write-channel FSM states
//   rstate_e  : read-channel FSM states
//   burst_err : burst-level legality check on an AW/AR payload
package axi4_burst_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_BURST} rstate_e;

  // Returns 1 when the whole burst must be answered with SLVERR.
  function automatic logic burst_err(input logic [31:0] addr,
                                     input logic [7:0]  len,
                                     input logic [2:0]  size,
                                     input logic [1:0]  burst,
                                     input int unsigned bytes);
    logic [31:0]  mask;
    logic [32:0]  first_byte;
    logic [32:0]  last_byte;
    int unsigned  lg;
    logic         err;
    lg = 0;
    for (int unsigned i = 1; i < 8; i++) begin
      if ((32'd1 << i) <= bytes) lg = i;
    end
    mask       = (32'd1 << size) - 32'd1;
    first_byte = {1'b0, addr & ~mask};
    last_byte  = first_byte + ((33'(len) + 33'd1) << size) - 33'd1;
    err        = 1'b0;
    if (32'(size) > lg) err = 1'b1;
    case (burst_e'(burst))
      RSVD: err = 1'b1;
      WRAP: begin
        if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) err = 1'b1;
        if ((addr & mask) != 32'd0) err = 1'b1;
      end
      INCR: if (last_byte[32:12] != first_byte[32:12]) err = 1'b1;
      default: ;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Per-burst beat address generator.
//   clk_i/rst_i      : clock, synchronous active-high reset
//   load_i           : capture addr/len/size/burst of a new burst
//   advance_i        : step to the next beat
//   word_o           : memory word index of the current beat
//   range_err_o      : current beat lies beyond the memory
//   last_o           : current beat is beat LEN+1
module axi4_burst_addr_gen
  import axi4_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned BYTES        = 4,
  parameter int unsigned MEMORY_DEPTH = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            load_i,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic [7:0]                      len_i,
  input  logic [2:0]                      size_i,
  input  logic [1:0]                      burst_i,
  input  logic                            advance_i,
  output logic [$clog2(MEMORY_DEPTH)-1:0] word_o,
  output logic                            range_err_o,
  output logic                            last_o
);

  localparam int unsigned OFFS  = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, cnt_q;
  logic [2:0]            size_q;
  burst_e                burst_q;
  logic [ADDR_WIDTH-1:0] step, aligned, span, wrap_base, incr_addr, widx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= FIXED;
      cnt_q   <= '0;
    end else if (load_i) begin
      addr_q  <= addr_i;
      len_q   <= len_i;
      size_q  <= size_i;
      burst_q <= burst_e'(burst_i);
      cnt_q   <= '0;
    end else if (advance_i) begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_q + 8'd1;
    end
  end

  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    aligned   = addr_q & ~(step - ADDR_WIDTH'(1));
    span      = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
    wrap_base = addr_q & ~(span - ADDR_WIDTH'(1));
    incr_addr = aligned + step;
    addr_d    = addr_q;
    case (burst_q)
      INCR:    addr_d = incr_addr;
      WRAP:    addr_d = (incr_addr == wrap_base + span) ? wrap_base : incr_addr;
      default: addr_d = addr_q;
    endcase
  end

  assign widx        = addr_q >> OFFS;
  assign word_o      = widx[IDX_W-1:0];
  assign range_err_o = 32'(widx) >= MEMORY_DEPTH;
  assign last_o      = (cnt_q == len_q);

endmodule

// File: rtl/axi4_burst_slave.sv
// AXI4 slave memory with FIXED/INCR/WRAP bursts, byte strobes, ID echo
// and a prefetching read path (1-cycle memory + 2-entry output buffer).
//   ACLK/ARESET        : clock, synchronous active-high reset
//   AW*/W*/B*          : write address, data and response channels
//   AR*/R*             : read address and data channels
module axi4_burst_slave
  import axi4_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned MEMORY_DEPTH = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH);

  wstate_e w_state_q, w_state_d;
  rstate_e r_state_q, r_state_d;

  logic aw_hs, w_hs, ar_hs, r_pop, r_issue;
  logic [IDX_W-1:0] w_word, r_word;
  logic w_range_err, r_range_err, w_last, r_last;

  logic [ID_WIDTH-1:0] bid_q, rid_q;
  logic wberr_q, wsticky_q, rberr_q, issued_all_q;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic                  mem_we;

  logic                  pipe_vld_q, pipe_err_q, pipe_last_q;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_resp_q [2];
  logic                  buf_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            buf_cnt_q, occ;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES), .MEMORY_DEPTH(MEMORY_DEPTH)) u_wgen (
    .clk_i(ACLK), .rst_i(ARESET), .load_i(aw_hs), .addr_i(AWADDR), .len_i(AWLEN),
    .size_i(AWSIZE), .burst_i(AWBURST), .advance_i(w_hs), .word_o(w_word),
    .range_err_o(w_range_err), .last_o(w_last)
  );

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES), .MEMORY_DEPTH(MEMORY_DEPTH)) u_rgen (
    .clk_i(ACLK), .rst_i(ARESET), .load_i(ar_hs), .addr_i(ARADDR), .len_i(ARLEN),
    .size_i(ARSIZE), .burst_i(ARBURST), .advance_i(r_issue), .word_o(r_word),
    .range_err_o(r_range_err), .last_o(r_last)
  );

  // ---------------- write channel ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  // Readies are masked by ARESET so nothing is accepted while in reset.
  always_comb begin
    w_state_d = w_state_q;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        AWREADY = !ARESET;
        if (AWVALID && !ARESET) w_state_d = W_DATA;
      end
      W_DATA: begin
        WREADY = !ARESET;
        if (WVALID && !ARESET && w_last) w_state_d = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign mem_we = w_hs && !wberr_q && !w_range_err;
  assign BID    = bid_q;
  assign BRESP  = (BVALID && (wberr_q || wsticky_q)) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bid_q     <= '0;
      wberr_q   <= 1'b0;
      wsticky_q <= 1'b0;
    end else begin
      if (aw_hs) begin
        bid_q     <= AWID;
        wberr_q   <= burst_err(32'(AWADDR), AWLEN, AWSIZE, AWBURST, BYTES);
        wsticky_q <= 1'b0;
      end
      if (w_hs && (w_range_err || (WLAST != w_last))) wsticky_q <= 1'b1;
    end
  end

  // Non-blocking read of the same word gives read-first behaviour.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (WSTRB[b]) mem[w_word][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
    if (r_issue) mem_rdata_q <= mem[r_word];
  end

  // ---------------- read channel ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    ARREADY   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ARREADY = !ARESET;
        if (ARVALID && !ARESET) r_state_d = R_BURST;
      end
      R_BURST: if (r_pop && RLAST) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  assign ar_hs  = ARVALID && ARREADY;
  assign RVALID = (buf_cnt_q != 2'd0);
  assign r_pop  = RVALID && RREADY;
  assign RID    = rid_q;
  assign RDATA  = buf_data_q[rd_ptr_q];
  assign RRESP  = buf_resp_q[rd_ptr_q];
  assign RLAST  = RVALID && buf_last_q[rd_ptr_q];

  // Beats in flight (buffered + in the memory stage) never exceed the two
  // buffer slots, so a new read issues only if a slot is free or draining.
  assign occ     = buf_cnt_q + {1'b0, pipe_vld_q};
  assign r_issue = (r_state_q == R_BURST) && !issued_all_q && ((occ < 2'd2) || r_pop);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rid_q        <= '0;
      rberr_q      <= 1'b0;
      issued_all_q <= 1'b0;
      pipe_vld_q   <= 1'b0;
      pipe_err_q   <= 1'b0;
      pipe_last_q  <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      buf_cnt_q    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_resp_q[i] <= RESP_OKAY;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      if (ar_hs) begin
        rid_q        <= ARID;
        rberr_q      <= burst_err(32'(ARADDR), ARLEN, ARSIZE, ARBURST, BYTES);
        issued_all_q <= 1'b0;
      end
      if (r_issue && r_last) issued_all_q <= 1'b1;
      pipe_vld_q  <= r_issue;
      pipe_err_q  <= rberr_q || r_range_err;
      pipe_last_q <= r_last;
      if (pipe_vld_q) begin
        buf_data_q[wr_ptr_q] <= pipe_err_q ? '0 : mem_rdata_q;
        buf_resp_q[wr_ptr_q] <= pipe_err_q ? RESP_SLVERR : RESP_OKAY;
        buf_last_q[wr_ptr_q] <= pipe_last_q;
        wr_ptr_q             <= !wr_ptr_q;
      end
      if (r_pop) rd_ptr_q <= !rd_ptr_q;
      buf_cnt_q <= buf_cnt_q + {1'b0, pipe_vld_q} - {1'b0, r_pop};
    end
  end

endmodule

// File: tb/tb_axi4_burst_slave.sv
// Directed self-checking bench for axi4_burst_slave (32-bit data).
module tb_axi4_burst_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0]  wr_bresp;
  logic [3:0]  wr_bid;
  logic [31:0] rd_data [32];
  logic [1:0]  rd_resp [32];
  logic        rd_last [32];
  logic [3:0]  rd_id   [32];
  int          rd_cyc  [32];
  int          rd_n;

  axi4_burst_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(4), .MEMORY_DEPTH(1024)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [31:0] data0,
                           input logic [3:0] strb, input int wlast_beat);
    int t;
    AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWID = id; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 50) begin @(posedge ACLK); #1; t++; end
    check("aw_wait", t < 50, 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    check("wready_after_aw", WREADY, 1);
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1; WDATA = data0 + 32'(i); WSTRB = strb; WLAST = (i == wlast_beat);
      t = 0;
      while (!WREADY && t < 50) begin @(posedge ACLK); #1; t++; end
      check("w_wait", t < 50, 1);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check("bvalid_after_w", BVALID, 1);
    wr_bresp = BRESP; wr_bid = BID;
    @(posedge ACLK); #1;
    check("b_hold", {BVALID, BRESP, BID}, {1'b1, wr_bresp, wr_bid});
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check("awready_after_b", {AWREADY, BVALID}, 2'b10);
  endtask

  task automatic axi_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int stall);
    int t, cyc, stall_left;
    logic [31:0] snap;
    ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARID = id; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 50) begin @(posedge ACLK); #1; t++; end
    check("ar_wait", t < 50, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    RREADY = (stall == 0);
    stall_left = stall;
    snap = '0;
    rd_n = 0;
    cyc = 0;
    while (rd_n < int'(len) + 1 && cyc < 300) begin
      if (RVALID) begin
        if (stall_left > 0) begin
          if (stall_left == stall) snap = RDATA;
          else check("r_hold", RDATA, snap);
          stall_left--;
          if (stall_left == 0) RREADY = 1'b1;
        end
        if (RREADY) begin
          rd_data[rd_n] = RDATA; rd_resp[rd_n] = RRESP; rd_last[rd_n] = RLAST;
          rd_id[rd_n] = RID; rd_cyc[rd_n] = cyc;
          rd_n++;
        end
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    RREADY = 1'b0;
    check("r_beats", rd_n, int'(len) + 1);
    check("arready_after_rlast", {ARREADY, RVALID}, 2'b10);
  endtask

  initial begin
    int beats, t;
    logic stray;
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check("reset_ctrl", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}, 6'b000000);
    check("reset_payload", {BRESP, RRESP, BID, RID, RDATA}, 44'h0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("ready_after_reset", {AWREADY, ARREADY}, 2'b11);

    // INCR write/readback with ID echo and a stalled first beat
    axi_write(16'h0010, 8'd3, 3'd2, 2'b01, 4'd5, 32'hA0, 4'hF, 3);
    check("incr_bresp", wr_bresp, 2'b00);
    check("incr_bid", wr_bid, 4'd5);
    axi_read(16'h0010, 8'd3, 3'd2, 2'b01, 4'd9, 3);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", rd_data[i], 32'hA0 + 32'(i));
      check("incr_rresp", rd_resp[i], 2'b00);
      check("incr_rlast", rd_last[i], i == 3);
      check("incr_rid", rd_id[i], 4'd9);
    end

    // WRAP write lands at 0x38,0x3C,0x30,0x34
    axi_write(16'h0038, 8'd3, 3'd2, 2'b10, 4'd2, 32'hB1, 4'hF, 3);
    check("wrap_bresp", wr_bresp, 2'b00);
    axi_read(16'h0030, 8'd3, 3'd2, 2'b01, 4'd1, 0);
    check("wrap_rd0", rd_data[0], 32'hB3);
    check("wrap_rd1", rd_data[1], 32'hB4);
    check("wrap_rd2", rd_data[2], 32'hB1);
    check("wrap_rd3", rd_data[3], 32'hB2);

    // Byte strobes
    axi_write(16'h0040, 8'd0, 3'd2, 2'b01, 4'd3, 32'h0000_0000, 4'hF, 0);
    axi_write(16'h0040, 8'd0, 3'd2, 2'b01, 4'd3, 32'hFFFF_FFFF, 4'b0101, 0);
    axi_read(16'h0040, 8'd0, 3'd2, 2'b01, 4'd3, 0);
    check("strobe_rdata", rd_data[0], 32'h00FF_00FF);
    check("strobe_rlast", rd_last[0], 1'b1);

    // 4 KB crossing: error, memory untouched
    axi_write(16'h0FF8, 8'd1, 3'd2, 2'b01, 4'd4, 32'h11, 4'hF, 1);
    check("pre4k_bresp", wr_bresp, 2'b00);
    axi_write(16'h0FF8, 8'd3, 3'd2, 2'b01, 4'd6, 32'hEE, 4'hF, 3);
    check("x4k_bresp", wr_bresp, 2'b10);
    check("x4k_bid", wr_bid, 4'd6);
    axi_read(16'h0FF8, 8'd1, 3'd2, 2'b01, 4'd0, 0);
    check("x4k_keep0", rd_data[0], 32'h11);
    check("x4k_keep1", rd_data[1], 32'h12);
    axi_read(16'h0FF8, 8'd3, 3'd2, 2'b01, 4'd7, 0);
    for (int i = 0; i < 4; i++) begin
      check("x4k_rresp", rd_resp[i], 2'b10);
      check("x4k_rdata", rd_data[i], 32'h0);
    end

    // Early WLAST and reserved burst type
    axi_write(16'h0050, 8'd1, 3'd2, 2'b01, 4'd8, 32'h55, 4'hF, 0);
    check("early_wlast_bresp", wr_bresp, 2'b10);
    axi_write(16'h0060, 8'd1, 3'd2, 2'b01, 4'd8, 32'h66, 4'hF, 99);
    check("missing_wlast_bresp", wr_bresp, 2'b10);
    axi_write(16'h0070, 8'd0, 3'd2, 2'b11, 4'd1, 32'h77, 4'hF, 0);
    check("rsvd_bresp", wr_bresp, 2'b10);

    // Out-of-range word
    axi_read(16'h1000, 8'd0, 3'd2, 2'b01, 4'd2, 0);
    check("range_rresp", rd_resp[0], 2'b10);
    check("range_rdata", rd_data[0], 32'h0);

    // Throughput: 16 beats back-to-back, first RVALID two cycles after AR
    axi_write(16'h0100, 8'd15, 3'd2, 2'b01, 4'd0, 32'h1000, 4'hF, 15);
    axi_read(16'h0100, 8'd15, 3'd2, 2'b01, 4'hC, 0);
    check("tp_first_latency", rd_cyc[0], 2);
    check("tp_span", rd_cyc[15] - rd_cyc[0], 15);
    for (int i = 0; i < 16; i++) begin
      check("tp_rdata", rd_data[i], 32'h1000 + 32'(i));
      check("tp_rlast", rd_last[i], i == 15);
    end

    // Reset during beat 2 of an 8-beat read
    ARADDR = 16'h0100; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = 2'b01; ARID = 4'd3; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 50) begin @(posedge ACLK); #1; t++; end
    @(posedge ACLK); #1;
    ARVALID = 1'b0; RREADY = 1'b1;
    beats = 0; t = 0;
    while (beats < 2 && t < 50) begin
      if (RVALID) beats++;
      if (beats < 2) begin @(posedge ACLK); #1; t++; end
    end
    check("rst_rd_reached_beat2", beats, 2);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("rst_rd_outputs", {RVALID, RLAST, ARREADY, RRESP, RID, RDATA}, 41'h0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("rst_rd_arready", ARREADY, 1'b1);
    stray = RVALID;
    repeat (5) begin @(posedge ACLK); #1; stray = stray | RVALID; end
    check("rst_rd_no_beats", stray, 1'b0);
    RREADY = 1'b0;
    axi_read(16'h0010, 8'd0, 3'd2, 2'b01, 4'd1, 0);
    check("post_rst_rdata", rd_data[0], 32'hA0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
